// File: rtl/rv32_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32_wb_stage
// Brief    : Writeback select, 32x32 register file with bypass, halt, retire count
// Revision : 1.0
// ============================================================================
module rv32_wb_stage #(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      alu_res_in,
    input  logic [31:0]      bshift_in,
    input  logic [31:0]      pc_ret_in,
    input  logic [31:0]      data_res_in,
    input  logic [2:0]       rf_in,
    input  logic [31:0]      code_in,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [31:0]      rs1_data,
    output logic [31:0]      rs2_data,
    output logic             wb_we_q,
    output logic [4:0]       wb_rd_q,
    output logic [31:0]      wb_data_q,
    output logic [CNT_W-1:0] retired_count,
    output logic             halted
);

    localparam logic [31:0] C_NOP    = 32'h0000_0013;
    localparam logic [31:0] C_EBREAK = 32'h0010_0073;

    logic [31:0]      r_regs [1:31];
    logic             r_wb_we;
    logic [4:0]       r_wb_rd;
    logic [31:0]      r_wb_data;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;

    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_wb_val;
    logic        w_we_eff;
    logic        w_byp_en;

    assign w_rd     = code_in[11:7];
    assign w_funct3 = code_in[14:12];
    assign w_off    = alu_res_in[1:0];
    assign w_we_eff = rf_in[0] && (w_rd != 5'd0) && !r_halted;

    // Halfword lanes ignore off[0]; misaligned halfwords simply pick the containing lane.
    always_comb begin
        w_byte = data_res_in[7:0];
        case (w_off)
            2'd1:    w_byte = data_res_in[15:8];
            2'd2:    w_byte = data_res_in[23:16];
            2'd3:    w_byte = data_res_in[31:24];
            default: w_byte = data_res_in[7:0];
        endcase
        w_half = w_off[1] ? data_res_in[31:16] : data_res_in[15:0];
        case (w_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = data_res_in;
        endcase
    end

    always_comb begin
        case (rf_in[2:1])
            2'b00:   w_wb_val = alu_res_in;
            2'b01:   w_wb_val = bshift_in;
            2'b10:   w_wb_val = pc_ret_in;
            default: w_wb_val = w_load;
        endcase
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_byp_en = w_we_eff;
        end else begin : g_no_bypass
            assign w_byp_en = 1'b0;
        end
    endgenerate

    always_comb begin
        rs1_data = 32'd0;
        if (rs1_addr != 5'd0) begin
            if (w_byp_en && (rs1_addr == w_rd)) rs1_data = w_wb_val;
            else                                rs1_data = r_regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = 32'd0;
        if (rs2_addr != 5'd0) begin
            if (w_byp_en && (rs2_addr == w_rd)) rs2_data = w_wb_val;
            else                                rs2_data = r_regs[rs2_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) r_regs[i] <= 32'd0;
            r_wb_we   <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
            r_count   <= '0;
            r_halted  <= 1'b0;
        end else begin
            if (w_we_eff) r_regs[w_rd] <= w_wb_val;
            r_wb_we   <= w_we_eff;
            r_wb_rd   <= w_we_eff ? w_rd : 5'd0;
            r_wb_data <= w_we_eff ? w_wb_val : 32'd0;
            // Bubbles do not retire; the counter holds at all-ones instead of wrapping.
            if (!r_halted && (code_in != C_NOP) && (r_count != {CNT_W{1'b1}}))
                r_count <= r_count + CNT_W'(1);
            if (!r_halted && (code_in == C_EBREAK))
                r_halted <= 1'b1;
        end
    end

    assign wb_we_q       = r_wb_we;
    assign wb_rd_q       = r_wb_rd;
    assign wb_data_q     = r_wb_data;
    assign retired_count = r_count;
    assign halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_rv32_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_wb_stage
// Brief    : Directed self-checking bench for rv32_wb_stage (three configurations)
// Revision : 1.0
// ============================================================================
module tb_rv32_wb_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_res_in, bshift_in, pc_ret_in, data_res_in, code_in;
    logic [2:0]  rf_in;
    logic [4:0]  rs1_addr, rs2_addr;

    logic [31:0] rs1_data, rs2_data, wb_data_q, retired_count;
    logic        wb_we_q, halted;
    logic [4:0]  wb_rd_q;

    logic [31:0] nb_rs1, nb_rs2, nb_wb_data, nb_cnt;
    logic        nb_we, nb_halted;
    logic [4:0]  nb_rd;

    logic [31:0] st_rs1, st_rs2, st_wb_data;
    logic [3:0]  st_cnt;
    logic        st_we, st_halted;
    logic [4:0]  st_rd;

    int n_pass  = 0;
    int n_total = 0;

    rv32_wb_stage u_dut (
        .clk(clk), .rst_n(rst_n), .alu_res_in(alu_res_in), .bshift_in(bshift_in),
        .pc_ret_in(pc_ret_in), .data_res_in(data_res_in), .rf_in(rf_in), .code_in(code_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_we_q(wb_we_q), .wb_rd_q(wb_rd_q), .wb_data_q(wb_data_q),
        .retired_count(retired_count), .halted(halted)
    );

    rv32_wb_stage #(.BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .alu_res_in(alu_res_in), .bshift_in(bshift_in),
        .pc_ret_in(pc_ret_in), .data_res_in(data_res_in), .rf_in(rf_in), .code_in(code_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(nb_rs1), .rs2_data(nb_rs2),
        .wb_we_q(nb_we), .wb_rd_q(nb_rd), .wb_data_q(nb_wb_data),
        .retired_count(nb_cnt), .halted(nb_halted)
    );

    rv32_wb_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .alu_res_in(alu_res_in), .bshift_in(bshift_in),
        .pc_ret_in(pc_ret_in), .data_res_in(data_res_in), .rf_in(rf_in), .code_in(code_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(st_rs1), .rs2_data(st_rs2),
        .wb_we_q(st_we), .wb_rd_q(st_rd), .wb_data_q(st_wb_data),
        .retired_count(st_cnt), .halted(st_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Non-NOP instruction with the given rd and funct3 (opcode 0x03).
    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, 7'b0000011};
    endfunction

    task automatic idle();
        rf_in = 3'b000; code_in = 32'h0000_0013;
        alu_res_in = 32'd0; bshift_in = 32'd0; pc_ret_in = 32'd0; data_res_in = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(32 - i);
            #1;
            n_total++;
            if (rs1_data !== 32'd0 || rs2_data !== 32'd0)
                $display("FAIL reset_reg x%0d: got %h/%h want 0", i, rs1_data, rs2_data);
            else n_pass++;
        end
        n_total++;
        if (retired_count !== 32'd0 || halted !== 1'b0 || wb_we_q !== 1'b0 ||
            wb_rd_q !== 5'd0 || wb_data_q !== 32'd0)
            $display("FAIL reset_state: cnt=%h halt=%b we=%b rd=%h data=%h want zeros",
                     retired_count, halted, wb_we_q, wb_rd_q, wb_data_q);
        else n_pass++;

        // Commit a write, then assert reset between edges.
        rf_in = 3'b001; code_in = mk(5'd7, 3'd0); alu_res_in = 32'hAAAA_5555;
        @(posedge clk); #1;
        idle(); rs1_addr = 5'd7;
        #1;
        n_total++;
        if (rs1_data !== 32'hAAAA_5555 || wb_we_q !== 1'b1 || retired_count !== 32'd1)
            $display("FAIL pre_async_reset: rs1=%h we=%b cnt=%h want aaaa5555/1/1",
                     rs1_data, wb_we_q, retired_count);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (rs1_data !== 32'd0 || wb_we_q !== 1'b0 || wb_rd_q !== 5'd0 ||
            wb_data_q !== 32'd0 || retired_count !== 32'd0)
            $display("FAIL async_reset: rs1=%h we=%b rd=%h data=%h cnt=%h want zeros",
                     rs1_data, wb_we_q, wb_rd_q, wb_data_q, retired_count);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        do_reset();
        rf_in = 3'b001; code_in = mk(5'd5, 3'd0); alu_res_in = 32'h1234_5678;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        n_total++;
        if (rs1_data !== 32'h1234_5678 || rs2_data !== 32'h1234_5678)
            $display("FAIL bypass_both: got %h/%h want 12345678", rs1_data, rs2_data);
        else n_pass++;
        n_total++;
        if (nb_rs1 !== 32'd0)
            $display("FAIL nobypass_read: got %h want 00000000", nb_rs1);
        else n_pass++;
        @(posedge clk); #1;
        idle(); rs1_addr = 5'd5;
        #1;
        n_total++;
        if (wb_we_q !== 1'b1 || wb_rd_q !== 5'd5 || wb_data_q !== 32'h1234_5678)
            $display("FAIL wb_copy: we=%b rd=%0d data=%h want 1/5/12345678",
                     wb_we_q, wb_rd_q, wb_data_q);
        else n_pass++;
        n_total++;
        if (rs1_data !== 32'h1234_5678 || nb_rs1 !== 32'h1234_5678)
            $display("FAIL array_read: got %h/%h want 12345678", rs1_data, nb_rs1);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (wb_we_q !== 1'b0 || wb_rd_q !== 5'd0 || wb_data_q !== 32'd0)
            $display("FAIL wb_copy_idle: we=%b rd=%0d data=%h want 0/0/0",
                     wb_we_q, wb_rd_q, wb_data_q);
        else n_pass++;
    endtask

    task automatic test_load();
        logic [2:0]  f3  [8] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1, 3'd3};
        logic [1:0]  off [8] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
        logic [31:0] exp [8] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rf_in = 3'b111; code_in = mk(5'd8, f3[i]);
            data_res_in = 32'h80FF_7F01; alu_res_in = {30'h0000_1000, off[i]};
            rs1_addr = 5'd8;
            #1;
            n_total++;
            if (rs1_data !== exp[i])
                $display("FAIL load_%0d f3=%0d off=%0d: got %h want %h", i, f3[i], off[i], rs1_data, exp[i]);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (wb_data_q !== exp[i])
                $display("FAIL load_wb_%0d: got %h want %h", i, wb_data_q, exp[i]);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_x0_and_sources();
        do_reset();
        rf_in = 3'b001; code_in = mk(5'd0, 3'd0); alu_res_in = 32'hDEAD_BEEF; rs1_addr = 5'd0;
        #1;
        n_total++;
        if (rs1_data !== 32'd0) $display("FAIL x0_read: got %h want 0", rs1_data);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (wb_we_q !== 1'b0 || wb_data_q !== 32'd0)
            $display("FAIL x0_write: we=%b data=%h want 0/0", wb_we_q, wb_data_q);
        else n_pass++;
        rf_in = 3'b101; code_in = mk(5'd9, 3'd0);
        alu_res_in = 32'h1111_1111; bshift_in = 32'h2222_2222; pc_ret_in = 32'h0000_0104;
        @(posedge clk); #1;
        rf_in = 3'b011; code_in = mk(5'd10, 3'd0); bshift_in = 32'hF0F0_0001;
        @(posedge clk); #1;
        idle(); rs1_addr = 5'd9; rs2_addr = 5'd10;
        #1;
        n_total++;
        if (rs1_data !== 32'h0000_0104) $display("FAIL sel_pc_ret: got %h want 00000104", rs1_data);
        else n_pass++;
        n_total++;
        if (rs2_data !== 32'hF0F0_0001) $display("FAIL sel_bshift: got %h want f0f00001", rs2_data);
        else n_pass++;
    endtask

    task automatic test_halt();
        logic [31:0] seq_code [4] = '{32'h0010_0093, 32'h0000_0013, 32'h0020_0113, 32'h0010_0073};
        logic [2:0]  seq_rf   [4] = '{3'b001, 3'b000, 3'b001, 3'b000};
        logic [31:0] seq_alu  [4] = '{32'd1, 32'd0, 32'd2, 32'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            code_in = seq_code[i]; rf_in = seq_rf[i]; alu_res_in = seq_alu[i];
            #1;
            if (i == 3) begin
                n_total++;
                if (halted !== 1'b0) $display("FAIL halt_early: got %b want 0", halted);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_total++;
        if (halted !== 1'b1 || retired_count !== 32'd3)
            $display("FAIL halt_set: halt=%b cnt=%0d want 1/3", halted, retired_count);
        else n_pass++;
        code_in = 32'h0060_0313; rf_in = 3'b001; alu_res_in = 32'h66; rs1_addr = 5'd6;
        #1;
        n_total++;
        if (rs1_data !== 32'd0) $display("FAIL halt_no_bypass: got %h want 0", rs1_data);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        idle(); rs1_addr = 5'd6; rs2_addr = 5'd2;
        #1;
        n_total++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd2 || wb_we_q !== 1'b0)
            $display("FAIL halt_frozen_rf: x6=%h x2=%h we=%b want 0/2/0", rs1_data, rs2_data, wb_we_q);
        else n_pass++;
        n_total++;
        if (retired_count !== 32'd3 || halted !== 1'b1)
            $display("FAIL halt_frozen_cnt: cnt=%0d halt=%b want 3/1", retired_count, halted);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        code_in = mk(5'd1, 3'd0); rf_in = 3'b000;
        repeat (14) @(posedge clk);
        #1;
        n_total++;
        if (st_cnt !== 4'hE) $display("FAIL sat_14: got %h want e", st_cnt);
        else n_pass++;
        repeat (6) @(posedge clk);
        #1;
        n_total++;
        if (st_cnt !== 4'hF || retired_count !== 32'd20)
            $display("FAIL sat_20: got %h/%0d want f/20", st_cnt, retired_count);
        else n_pass++;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_bypass();
        test_load();
        test_x0_and_sources();
        test_saturation();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
